// File: rtl/game_flow_fsm_if.sv
// rtl/game_flow_fsm_if.sv - input events and screen outputs of the game flow sequencer
interface game_flow_fsm_if #(
    parameter int KEY_W  = 8,
    parameter int PAGE_W = 3
);
    logic              frame_tick;
    logic [KEY_W-1:0]  keycode;
    logic              battle_start;
    logic              player_dead;
    logic              battle_won;
    logic [3:0]        status;
    logic [PAGE_W-1:0] intro_page;
    logic              state_changed;

    modport master (
        output frame_tick, keycode, battle_start, player_dead, battle_won,
        input  status, intro_page, state_changed
    );

    modport slave (
        input  frame_tick, keycode, battle_start, player_dead, battle_won,
        output status, intro_page, state_changed
    );
endinterface

// File: rtl/game_flow_fsm.sv
// rtl/game_flow_fsm.sv - TITLE / paged INTRO / OVERWORLD / BATTLE / GAMEOVER screen sequencer
module game_flow_fsm #(
    parameter int               KEY_W           = 8,
    parameter logic [KEY_W-1:0] ENTER_KEY       = 8'h28,
    parameter logic [KEY_W-1:0] BACK_KEY        = 8'h20,
    parameter int               INTRO_PAGES     = 4,
    parameter int               INTRO_FRAMES    = 240,
    parameter int               GAMEOVER_FRAMES = 120
) (
    input  logic          Clk,
    input  logic          Reset,
    game_flow_fsm_if.slave bus
);
    localparam int PAGE_W     = $clog2(INTRO_PAGES) + 1;
    localparam int MAX_FRAMES = (INTRO_FRAMES > GAMEOVER_FRAMES) ? INTRO_FRAMES : GAMEOVER_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    typedef enum logic [2:0] {
        S_TITLE     = 3'd1,
        S_INTRO     = 3'd2,
        S_OVERWORLD = 3'd3,
        S_BATTLE    = 3'd4,
        S_GAMEOVER  = 3'd5
    } state_t;

    state_t            state, next_state;
    logic [PAGE_W-1:0] page, next_page;
    logic [CNT_W-1:0]  frame_cnt;
    logic [KEY_W-1:0]  prev_key;
    logic              changed_q;

    logic enter_press, back_press, intro_timeout, gameover_ready, last_page, moved;

    assign enter_press    = (bus.keycode == ENTER_KEY) && (prev_key != ENTER_KEY);
    assign back_press     = (bus.keycode == BACK_KEY) && (prev_key != BACK_KEY);
    assign intro_timeout  = bus.frame_tick && (frame_cnt == CNT_W'(INTRO_FRAMES - 1));
    assign gameover_ready = frame_cnt >= CNT_W'(GAMEOVER_FRAMES);
    assign last_page      = page == PAGE_W'(INTRO_PAGES - 1);

    always_comb begin
        next_state = state;
        next_page  = page;
        case (state)
            S_TITLE: begin
                if (enter_press) begin
                    next_state = S_INTRO;
                    next_page  = '0;
                end
            end
            S_INTRO: begin
                if (back_press) begin
                    next_state = S_TITLE;
                    next_page  = '0;
                end else if (enter_press || intro_timeout) begin
                    if (last_page) begin
                        next_state = S_OVERWORLD;
                        next_page  = '0;
                    end else begin
                        next_page = page + PAGE_W'(1);
                    end
                end
            end
            S_OVERWORLD: begin
                if (bus.battle_start)
                    next_state = S_BATTLE;
                else if (back_press)
                    next_state = S_TITLE;
            end
            S_BATTLE: begin
                if (bus.player_dead)
                    next_state = S_GAMEOVER;
                else if (bus.battle_won)
                    next_state = S_OVERWORLD;
            end
            S_GAMEOVER: begin
                // Presses during the hold are dropped, not queued.
                if (gameover_ready && enter_press)
                    next_state = S_TITLE;
            end
            default: begin
                next_state = S_TITLE;
                next_page  = '0;
            end
        endcase
    end

    assign moved = (next_state != state) || (next_page != page);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_TITLE;
            page      <= '0;
            frame_cnt <= '0;
            prev_key  <= '0;
            changed_q <= 1'b0;
        end else begin
            state     <= next_state;
            page      <= next_page;
            prev_key  <= bus.keycode;
            changed_q <= moved;
            if (moved)
                frame_cnt <= '0;
            else if (bus.frame_tick && (frame_cnt != '1))
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        case (state)
            S_TITLE, S_INTRO, S_OVERWORLD, S_BATTLE, S_GAMEOVER: bus.status = {1'b0, state};
            default:                                             bus.status = 4'd0;
        endcase
    end

    assign bus.intro_page    = page;
    assign bus.state_changed = changed_q;
endmodule

// File: doc/game_flow_fsm.md
Name: game_flow_fsm

Overview:
Top-level game-screen sequencer for the Undertale build. It supersedes the two-screen title/intro controller with a parametrised multi-screen flow: TITLE, paged INTRO, OVERWORLD, BATTLE and GAMEOVER. The flow is driven by edge-detected keyboard presses, frame ticks and gameplay events. It sits between the USB keycode path and the renderer/sprite muxes, which select content from status and intro_page.

Parameters:
KEY_W, 8, keycode width
ENTER_KEY, 8'h28, advance/confirm key
BACK_KEY, 8'h20, return-to-title key
INTRO_PAGES, 4, number of intro pages (>=1)
INTRO_FRAMES, 240, frame ticks before an intro page auto-advances (>=1)
GAMEOVER_FRAMES, 120, frame ticks before ENTER is accepted in GAMEOVER (>=1)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous active-high reset
frame_tick  in  1  one-Clk pulse per video frame (vsync)
keycode  in  KEY_W  current key, 0 = none
battle_start  in  1  encounter trigger, sampled in OVERWORLD only
player_dead  in  1  HP reached 0, sampled in BATTLE only
battle_won  in  1  enemy defeated, sampled in BATTLE only
status  out  4  screen code: 0 undefined, 1 TITLE, 2 INTRO, 3 OVERWORLD, 4 BATTLE, 5 GAMEOVER
intro_page  out  clog2(INTRO_PAGES)+1  current intro page, 0-based
state_changed  out  1  one-cycle pulse in the first cycle after any state change or page change

Interface decision: one clock, Clk; reset is asynchronous and active-high, named Reset.

Behaviour:
- Reset (async assert, released on Clk): state=TITLE, intro_page=0, frame counter=0, key history=0, state_changed=0. status therefore reads 1 during reset.
- Key press detection: prev_key is registered every Clk. press(K) = (keycode==K) && (prev_key!=K). A held key produces exactly one press. Reset clears prev_key, so a key already held when Reset releases counts as a press on the first cycle.
- frame_cnt counts frame_tick pulses. It clears on every state or page transition and saturates at its maximum.
- status is a combinational decode of the registered state, so it changes in the same cycle the state register updates. Transitions take effect on the Clk edge after the qualifying condition. Latency is 1 cycle.
- TITLE: press(ENTER) -> INTRO with page 0.
- INTRO:
  - press(BACK) -> TITLE and page=0. BACK has priority over everything else.
  - Otherwise, press(ENTER), or frame_cnt reaching INTRO_FRAMES-1 while frame_tick is high, advances the page.
  - If the page is INTRO_PAGES-1, the advance goes to OVERWORLD and page=0.
  - A press and the timeout in the same cycle advance the page by one only.
- OVERWORLD: battle_start -> BATTLE. press(BACK) -> TITLE. battle_start has priority over BACK.
- BATTLE: player_dead -> GAMEOVER; battle_won -> OVERWORLD. player_dead has priority when both are high. Keys are ignored.
- GAMEOVER: press(ENTER) is ignored until frame_cnt >= GAMEOVER_FRAMES. After that, press(ENTER) -> TITLE. A press that occurs while the hold is active is not remembered.
- Event inputs are ignored in states other than those listed above.
- state_changed is registered: it is high for exactly one Clk after each state or page update. Two transitions on consecutive cycles give two consecutive pulses.
- Illegal or unused state encodings recover to TITLE on the next Clk, with status=0 while illegal.
- Reset asserted mid-operation (mid-page, mid-hold) immediately forces the reset values with no clock required.

Test Plan:
- Reset, hold keycode=0 for 5 cycles -> status=1, intro_page=0, state_changed=0. Then keycode=8'h28 held for 10 cycles -> status=2 after 1 cycle, exactly one state_changed pulse, no further page advance while the key is held.
- In INTRO, press ENTER 3 times (release between presses) with INTRO_PAGES=4 -> intro_page goes 1,2,3. The 4th press gives status=3 and intro_page=0.
- In INTRO with no key, issue 240 frame_tick pulses -> intro_page increments on the 240th tick. Press BACK on page 2 -> status=1, intro_page=0.
- In OVERWORLD, assert battle_start and BACK in the same cycle -> status=4. In BATTLE, assert player_dead and battle_won together -> status=5.
- In GAMEOVER, press ENTER after 50 ticks -> status stays 5. After 120 ticks, press ENTER -> status=1 with a state_changed pulse.
- Assert Reset asynchronously (between Clk edges) while in BATTLE -> status=1 before the next Clk edge. Release Reset while 8'h28 is held -> INTRO on the first Clk.
